// File: rtl/subpel_row_scheduler.sv
// Fetches BLK_ROWS consecutive frame rows (wrapping at IMG_ROWS) from the row store
// and pushes them one per dp_load into the sub-pel interpolation FIR window.
module subpel_row_scheduler #(
  parameter int ADDR_W   = 15,
  parameter int IMG_ROWS = 28800,
  parameter int BLK_ROWS = 15,
  parameter int TAPS     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] base_row,
  input  logic              abort,
  output logic              row_req,
  output logic [ADDR_W-1:0] row_addr,
  input  logic              row_ack,
  input  logic [119:0]      row_data,
  output logic [119:0]      dp_row,
  output logic              dp_load,
  input  logic              dp_busy,
  output logic              dp_out_valid,
  output logic [2:0]        out_row_idx,
  output logic              blk_done,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  // Handshakes: a command transfers on start && start_ready; a row transfers on
  // row_req && row_ack (row_req/row_addr hold until then); dp_load fires only while !dp_busy.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PUSH  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] IMG_ROWS_W = (ADDR_W+1)'(IMG_ROWS);
  localparam logic [4:0]      BLK_ROWS_W = 5'(BLK_ROWS);
  localparam logic [4:0]      TAPS_W     = 5'(TAPS);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base;
  logic [3:0]        cnt;
  logic [4:0]        cnt_inc;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W:0]   addr_wrap;
  logic              accept;
  logic              take_row;

  assign cnt_inc   = {1'b0, cnt} + 5'd1;
  // One extra bit so base+cnt never truncates before the modulo fold.
  assign addr_sum  = {1'b0, base} + {{(ADDR_W-3){1'b0}}, cnt};
  assign addr_wrap = (addr_sum >= IMG_ROWS_W) ? (addr_sum - IMG_ROWS_W) : addr_sum;
  assign accept    = start && (state == IDLE);
  assign take_row  = (state == FETCH) && row_ack && !abort;

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign blk_done    = (state == DONE);
  assign dbg_state   = state;

  always_comb begin
    state_next = state;
    row_req    = 1'b0;
    row_addr   = '0;
    dp_load    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        row_req  = 1'b1;
        row_addr = addr_wrap[ADDR_W-1:0];
        if (abort)        state_next = IDLE;
        else if (row_ack) state_next = PUSH;
      end
      PUSH: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!dp_busy) begin
          dp_load    = 1'b1;
          state_next = (cnt_inc < BLK_ROWS_W) ? FETCH : DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      cnt          <= '0;
      dp_row       <= '0;
      dp_out_valid <= 1'b0;
      out_row_idx  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        base <= base_row;
        cnt  <= '0;
      end else if (dp_load) begin
        cnt <= cnt_inc[3:0];
      end
      if (take_row) dp_row <= row_data;
      // The FIR produces a row once the window holds at least TAPS rows.
      dp_out_valid <= dp_load && (cnt_inc >= TAPS_W);
      out_row_idx  <= (dp_load && (cnt_inc >= TAPS_W)) ? 3'(cnt_inc - TAPS_W) : 3'd0;
    end
  end
endmodule

// File: tb/tb_subpel_row_scheduler.sv
// Bench for subpel_row_scheduler: table-driven blocks, random blocks, and hand-written
// abort / mid-block start / reset sequences, all against a spec-level model.
module tb_subpel_row_scheduler;
  localparam int ADDR_W   = 15;
  localparam int IMG_ROWS = 28800;
  localparam int BLK_ROWS = 15;
  localparam int TAPS     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              start_ready;
  logic [ADDR_W-1:0] base_row;
  logic              abort;
  logic              row_req;
  logic [ADDR_W-1:0] row_addr;
  logic              row_ack;
  logic [119:0]      row_data;
  logic [119:0]      dp_row;
  logic              dp_load;
  logic              dp_busy;
  logic              dp_out_valid;
  logic [2:0]        out_row_idx;
  logic              blk_done;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int base;
    int delay;
    int stall_row;
    int stall_len;
    int exp_cycles;
    int exp_first;
    int exp_last;
  } vec_t;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  subpel_row_scheduler #(
    .ADDR_W(ADDR_W), .IMG_ROWS(IMG_ROWS), .BLK_ROWS(BLK_ROWS), .TAPS(TAPS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .base_row(base_row), .abort(abort), .row_req(row_req), .row_addr(row_addr),
    .row_ack(row_ack), .row_data(row_data), .dp_row(dp_row), .dp_load(dp_load),
    .dp_busy(dp_busy), .dp_out_valid(dp_out_valid), .out_row_idx(out_row_idx),
    .blk_done(blk_done), .busy(busy), .dbg_state(dbg_state)
  );

  // Row store contents: every address holds a distinct, recognisable 120-bit row.
  function automatic logic [119:0] row_of(input int a);
    logic [14:0] w;
    w = 15'(a) ^ 15'h2a5b;
    return {8{w}};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_row(input string name, input logic [119:0] act, input logic [119:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic idle_inputs();
    start   = 1'b0;
    abort   = 1'b0;
    row_ack = 1'b0;
    dp_busy = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_row_req"}, int'(row_req), 0);
    check({tag, "_dp_load"}, int'(dp_load), 0);
    check({tag, "_dp_out_valid"}, int'(dp_out_valid), 0);
    check({tag, "_blk_done"}, int'(blk_done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_start_ready"}, int'(start_ready), 1);
  endtask

  // driver + scoreboard for one block; called at a negedge, returns just after a sample
  task automatic run_block(input int b, input int delay, input int stall_row, input int stall_len,
                           input int abort_at, input int mid_start_at, input int rst_at,
                           input bit stray, output int cycles, output int loads,
                           output int valids, output bit done_seen,
                           output int first_addr, output int last_addr);
    logic [ADDR_W-1:0] exp_q[$];
    int                load_q[$];
    int                cyc, first_fetch, waited, acks, stall_left, ea;
    bit                in_push, prev_wait, prev_load, exp_load, exp_done, mid_done, stop;
    logic [ADDR_W-1:0] prev_addr;
    logic [119:0]      held_row;
    for (int i = 0; i < BLK_ROWS; i++) exp_q.push_back(ADDR_W'((b + i) % IMG_ROWS));
    loads = 0; valids = 0; done_seen = 1'b0; cycles = -1; first_addr = -1; last_addr = -1;
    cyc = 0; first_fetch = -1; waited = 0; acks = 0; stall_left = stall_len;
    in_push = 1'b0; prev_wait = 1'b0; prev_load = 1'b0; mid_done = 1'b0; stop = 1'b0;
    prev_addr = '0; held_row = '0;
    idle_inputs();
    start = 1'b1;
    base_row = ADDR_W'(b);
    #1 check("start_ready_idle", int'(start_ready), 1);
    @(negedge clk);
    while (!stop && cyc < 300) begin
      idle_inputs();
      row_data = ~row_of(int'($urandom_range(0, 32767)));
      if (row_req) begin
        if (first_fetch < 0) first_fetch = cyc;
        row_data = row_of(int'(row_addr));
        if (waited >= delay) row_ack = 1'b1;
        else waited++;
      end else if (stray) begin
        row_ack = 1'($urandom_range(0, 1));
      end
      if (in_push && loads == stall_row && stall_left > 0) begin
        dp_busy = 1'b1;
        stall_left--;
      end
      if (row_req && row_ack && acks + 1 == abort_at) abort = 1'b1;
      if (row_req && loads == mid_start_at && !mid_done) begin
        start = 1'b1;
        base_row = 15'd100;
        mid_done = 1'b1;
      end
      if (row_req && loads == rst_at) rst = 1'b1;
      #1;
      if (start) check("start_ready_while_busy", int'(start_ready), 0);
      exp_done = prev_load && (loads == BLK_ROWS);
      check("dp_out_valid", int'(dp_out_valid), int'(prev_load && loads >= TAPS));
      check("blk_done", int'(blk_done), int'(exp_done));
      if (dp_out_valid) begin
        valids++;
        check("out_row_idx", int'(out_row_idx), loads - TAPS);
      end
      if (prev_wait) begin
        check("row_req_held", int'(row_req), 1);
        check("row_addr_stable", int'(row_addr), int'(prev_addr));
      end
      exp_load = in_push && !dp_busy && !abort;
      check("dp_load", int'(dp_load), int'(exp_load));
      if (in_push && dp_busy) check_row("dp_row_stall", dp_row, held_row);
      if (exp_load) begin
        ea = (load_q.size() > 0) ? load_q.pop_front() : -1;
        check_row("dp_row_load", dp_row, row_of(ea));
        loads++;
      end
      if (row_req && row_ack) begin
        acks++;
        waited = 0;
        ea = (exp_q.size() > 0) ? int'(exp_q.pop_front()) : -1;
        check("row_addr", int'(row_addr), ea);
        if (first_addr < 0) first_addr = int'(row_addr);
        last_addr = int'(row_addr);
        if (!abort) begin
          load_q.push_back(ea);
          held_row = row_of(ea);
        end
      end
      if (exp_done || blk_done) begin
        done_seen = blk_done;
        cycles = cyc - first_fetch;
        stop = 1'b1;
      end
      if (abort || rst) stop = 1'b1;
      in_push   = (row_req && row_ack && !abort) ? 1'b1 : (in_push && !exp_load);
      prev_wait = row_req && !row_ack && !abort;
      prev_addr = row_addr;
      prev_load = exp_load;
      cyc++;
      if (!stop) @(negedge clk);
    end
    check("block_terminated", int'(stop), 1);
    check("first_fetch_cycle", first_fetch, 0);
    if (done_seen) begin
      @(negedge clk);
      idle_inputs();
      #1 check_quiet("after_done");
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   cycles, loads, valids, fa, la;
    bit   done_seen;
    int   b, d, sr, sl;

    vecs[0] = '{0,     0, -1, 0, 30, 0,     14};
    vecs[1] = '{28790, 0, -1, 0, 30, 28790, 4};
    vecs[2] = '{0,     3,  5, 2, 77, 0,     14};
    vecs[3] = '{28799, 1,  0, 1, 46, 28799, 13};
    vecs[4] = '{28785, 2, 14, 3, 63, 28785, 28799};

    rst = 1'b1;
    idle_inputs();
    base_row = '0;
    row_data = '0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    base_row = 15'd77;
    @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_row_addr", int'(row_addr), 0);
    check("reset_out_row_idx", int'(out_row_idx), 0);
    check("reset_state", int'(dbg_state), 0);
    check_row("reset_dp_row", dp_row, '0);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    #1 check("start_under_reset_ignored", int'(busy), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      run_block(vecs[i].base, vecs[i].delay, vecs[i].stall_row, vecs[i].stall_len, -1, -1, -1,
                1'b0, cycles, loads, valids, done_seen, fa, la);
      check("vec_done_seen", int'(done_seen), 1);
      check("vec_cycles", cycles, vecs[i].exp_cycles);
      check("vec_loads", loads, BLK_ROWS);
      check("vec_valids", valids, BLK_ROWS - TAPS + 1);
      check("vec_first_addr", fa, vecs[i].exp_first);
      check("vec_last_addr", la, vecs[i].exp_last);
    end

    for (int n = 0; n < 6; n++) begin
      b  = (n % 2 == 0) ? int'($urandom_range(IMG_ROWS - 20, IMG_ROWS - 1))
                        : int'($urandom_range(0, IMG_ROWS - 1));
      d  = int'($urandom_range(0, 3));
      sr = int'($urandom_range(0, BLK_ROWS - 1));
      sl = int'($urandom_range(0, 3));
      @(negedge clk);
      run_block(b, d, sr, sl, -1, -1, -1, 1'b1, cycles, loads, valids, done_seen, fa, la);
      check("rand_done_seen", int'(done_seen), 1);
      check("rand_cycles", cycles, BLK_ROWS * (d + 2) + sl);
      check("rand_loads", loads, BLK_ROWS);
      check("rand_first_addr", fa, b);
      check("rand_last_addr", la, (b + BLK_ROWS - 1) % IMG_ROWS);
    end

    // abort on the 10th row_ack
    @(negedge clk);
    run_block(0, 0, -1, 0, 10, -1, -1, 1'b0, cycles, loads, valids, done_seen, fa, la);
    check("abort_loads", loads, 9);
    check("abort_valids", valids, 2);
    check("abort_no_done", int'(done_seen), 0);
    @(negedge clk);
    idle_inputs();
    #1 check_quiet("after_abort");

    // start ignored mid-block, then reset at row 6 and restart at once
    @(negedge clk);
    run_block(0, 0, -1, 0, -1, 3, 6, 1'b0, cycles, loads, valids, done_seen, fa, la);
    check("rst_blk_loads", loads, 6);
    check("rst_blk_first_addr", fa, 0);
    check("rst_blk_no_done", int'(done_seen), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check_quiet("after_rst");
    check_row("after_rst_dp_row", dp_row, '0);
    run_block(200, 0, -1, 0, -1, -1, -1, 1'b0, cycles, loads, valids, done_seen, fa, la);
    check("restart_done_seen", int'(done_seen), 1);
    check("restart_first_addr", fa, 200);
    check("restart_cycles", cycles, 30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
